// File: rtl/double_dabble_bcd2bin.sv
// Sequential BCD-to-binary converter (reverse double dabble) producing a signed,
// sign-extended two's-complement operand from sign-magnitude decimal digits.
module double_dabble_bcd2bin #(
    parameter int NUM_DIGITS  = 4,
    parameter int WIDTH       = 16,
    parameter int CHECK_PARAM = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [3:0]       bcd [NUM_DIGITS],
    input  logic             negative,
    output logic [WIDTH-1:0] bin,
    output logic             ready,
    output logic             done,
    output logic             error
);

    localparam int M  = $clog2(10 ** NUM_DIGITS);
    localparam int SW = 4 * NUM_DIGITS + M;
    localparam int CW = $clog2(M + 1);

    generate
        if (CHECK_PARAM != 0) begin : g_chk
            if (NUM_DIGITS == 0 || WIDTH < M + 1) begin : g_bad
                $fatal(1, "double_dabble_bcd2bin: NUM_DIGITS must be > 0 and WIDTH >= M+1");
            end
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic        [SW-1:0]     sr_q, sr_d;
    logic        [CW-1:0]     cnt_q, cnt_d;
    logic                     neg_q, neg_d;
    logic                     inv_q, inv_d;
    logic signed [WIDTH-1:0]  bin_q, bin_d;
    logic                     done_q, done_d;
    logic                     error_q, error_d;
    logic        [SW-1:0]     sr_load;
    logic                     bad_digit;

    // One reverse iteration: shift right, then pull every digit >= 8 back by 3.
    function automatic logic [SW-1:0] dd_step(input logic [SW-1:0] s);
        logic [SW-1:0] r;
        r = s >> 1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (r[M+4*j +: 4] >= 4'd8) begin
                r[M+4*j +: 4] = r[M+4*j +: 4] - 4'd3;
            end
        end
        return r;
    endfunction

    function automatic logic signed [WIDTH-1:0] apply_sign(input logic [M-1:0] mag,
                                                           input logic          neg);
        logic signed [WIDTH-1:0] x;
        x = $signed({{(WIDTH-M){1'b0}}, mag});
        return neg ? -x : x;
    endfunction

    always_comb begin
        sr_load   = '0;
        bad_digit = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            sr_load[M+4*j +: 4] = bcd[j];
            if (bcd[j] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        inv_d   = inv_q;
        bin_d   = bin_q;
        done_d  = done_q;
        error_d = error_q;
        if (en) begin
            done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (bad_digit) begin
                            inv_d   = 1'b1;
                            state_d = FINISH;
                        end else begin
                            inv_d   = 1'b0;
                            sr_d    = sr_load;
                            neg_d   = negative;
                            cnt_d   = CW'(M);
                            state_d = CONV;
                        end
                    end
                end
                CONV: begin
                    sr_d  = dd_step(sr_q);
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = FINISH;
                    end
                end
                FINISH: begin
                    done_d  = 1'b1;
                    error_d = inv_q;
                    bin_d   = inv_q ? '0 : apply_sign(sr_q[M-1:0], neg_q);
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Reset overrides en so an abort always lands in IDLE with cleared outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            inv_q   <= 1'b0;
            bin_q   <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            inv_q   <= inv_d;
            bin_q   <= bin_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign bin   = bin_q;
    assign ready = (state_q == IDLE);
    assign done  = done_q;
    assign error = error_q;

endmodule

// File: tb/tb_double_dabble_bcd2bin.sv
// Scoreboard bench for double_dabble_bcd2bin: decimal reference model, directed
// cases followed by randomized requests with random clock-enable gaps.
module tb_double_dabble_bcd2bin;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        start;
    logic [3:0]  bcd [4];
    logic        negative;
    logic [15:0] bin;
    logic        ready;
    logic        done;
    logic        error;

    typedef struct {
        logic [15:0] bin;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;

    double_dabble_bcd2bin #(.NUM_DIGITS(4), .WIDTH(16), .CHECK_PARAM(1)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .bcd(bcd),
        .negative(negative), .bin(bin), .ready(ready), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Decimal value of the digits, then negate modulo 2^16.
    function automatic exp_t model(input logic [15:0] dig, input logic neg);
        exp_t e;
        int   v;
        bit   inv;
        v   = 0;
        inv = 0;
        for (int j = 3; j >= 0; j--) begin
            if (int'(dig[4*j +: 4]) > 9) inv = 1;
            v = v * 10 + int'(dig[4*j +: 4]);
        end
        e.err = inv;
        if (inv) e.bin = 16'h0000;
        else     e.bin = neg ? 16'(-v) : 16'(v);
        return e;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (done && mon_en) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("bin", 32'(bin), 32'(e.bin));
                    chk("error", 32'(error), 32'(e.err));
                end
            end
            mon_en = en;
        end
    end

    // mode: 0 steady, 1 random en, 2 five-cycle stall, 3 start re-pulse, 4 reset abort
    task automatic run(input logic [15:0] dig, input logic neg, input int mode, input int exp_lat);
        exp_t        e;
        int          edges, en_edges, guard;
        logic        en_now, rdy_bad, frz_bad, aborted, got;
        logic [15:0] bin_hold;
        edges = 0; en_edges = 0; guard = 0;
        rdy_bad = 0; frz_bad = 0; aborted = 0; got = 0;
        while (ready !== 1'b1 && guard < 100) begin
            en = 1'b1;
            @(posedge clk); #1;
            guard++;
        end
        e = model(dig, neg);
        for (int j = 0; j < 4; j++) bcd[j] = dig[4*j +: 4];
        negative = neg;
        start    = 1'b1;
        en       = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        for (int j = 0; j < 4; j++) bcd[j] = 4'($urandom_range(0, 9));
        negative = 1'($urandom);
        bin_hold = bin;
        while (edges < 200) begin
            case (mode)
                1:       en_now = ($urandom_range(0, 3) != 0);
                2:       en_now = !(edges >= 5 && edges < 10);
                default: en_now = 1'b1;
            endcase
            if (mode == 3 && edges >= 4 && edges < 7) begin
                start = 1'b1;
                for (int j = 0; j < 4; j++) bcd[j] = 4'($urandom_range(0, 9));
            end else begin
                start = 1'b0;
            end
            if (mode == 4 && edges == 7) rst = 1'b1;
            en = en_now;
            @(posedge clk); #1;
            edges++;
            if (en_now) en_edges++;
            if (rst) begin
                rst     = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (done && en_now) begin
                got = 1'b1;
                break;
            end
            if (ready !== 1'b0) rdy_bad = 1'b1;
            if (!en_now && (bin !== bin_hold || done !== 1'b0)) frz_bad = 1'b1;
        end
        start = 1'b0;
        en    = 1'b1;
        if (aborted) begin
            chk("abort_ready", 32'(ready), 32'(1));
            chk("abort_bin", 32'(bin), 32'(0));
            chk("abort_done", 32'(done), 32'(0));
            chk("abort_error", 32'(error), 32'(0));
            void'(sb.pop_back());
        end else begin
            chk("done_seen", 32'(got), 32'(1));
            if (exp_lat >= 0) chk("latency", 32'(edges), 32'(exp_lat));
            chk("enabled_latency", 32'(en_edges), e.err ? 32'(1) : 32'(15));
            chk("ready_low", 32'(rdy_bad), 32'(0));
            chk("frozen", 32'(frz_bad), 32'(0));
        end
    endtask

    initial begin
        logic [15:0] dig;
        rst = 1'b1; en = 1'b1; start = 1'b0; negative = 1'b0;
        for (int j = 0; j < 4; j++) bcd[j] = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_bin", 32'(bin), 32'(0));
        chk("rst_ready", 32'(ready), 32'(1));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_error", 32'(error), 32'(0));

        run(16'h1234, 1'b0, 0, 15);
        run(16'h9999, 1'b1, 0, 15);
        run(16'h0000, 1'b1, 0, 15);
        run(16'h1A00, 1'b0, 0, 1);
        run(16'h0042, 1'b0, 0, 15);
        run(16'h0777, 1'b0, 2, 20);
        run(16'h0123, 1'b0, 3, 15);
        run(16'h0456, 1'b1, 4, -1);
        repeat (20) @(posedge clk);
        #1;

        for (int n = 0; n < 40; n++) begin
            for (int j = 0; j < 4; j++) begin
                dig[4*j +: 4] = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(10, 15))
                                                             : 4'($urandom_range(0, 9));
            end
            run(dig, 1'($urandom), int'($urandom_range(0, 1)), -1);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
